i2c_slave_responder: RTL
========================

// Module: i2c_slave_responder
// PURPOSE
//  Target (slave) end of the team's I2C link; counterpart to the master-side SDA data path.
//  Oversamples SCL/SDA on the core clock and detects START/STOP. Matches a 7-bit address, ACKs,
//  then receives bytes into the core (master write) or shifts core-supplied bytes out (master read).
//  Sits between the pads (SDA driven open-drain: 0 = pull low, 1 = release) and a FIFO-style core port.
// PARAMETERS
//  DATA_SIZE   8      data byte width; only 8 is supported, the parameter is kept for port sizing
//  ADDR_SIZE   7      slave address width
//  SLAVE_ADDR  7'h3C  own address compared against the first 7 bits after START
// PORTS
//  i2c_core_clk_i  in   1          core clock; all logic is on its rising edge
//  reset_i         in   1          asynchronous, active-high reset
//  i2c_scl_i       in   1          raw SCL from pad (asynchronous)
//  i2c_sda_i       in   1          raw SDA from pad (asynchronous)
//  i2c_sda_o       out  1          SDA drive: 0 = pull low, 1 = release
//  rx_full_i       in   1          core cannot accept a byte; the slave NACKs the current write byte
//  rx_data_o       out  DATA_SIZE  last received byte; held until the next byte
//  rx_valid_o      out  1          one-cycle pulse when rx_data_o updates
//  tx_data_i       in   DATA_SIZE  next byte for a master read
//  tx_valid_i      in   1          tx_data_i is valid
//  tx_ack_o        out  1          one-cycle pulse when tx_data_i is consumed
//  busy_o          out  1          high from the address match until the next STOP or START
//  stop_o          out  1          one-cycle pulse on STOP while addressed
// BEHAVIOUR
//  Reset: i2c_sda_o=1, rx_data_o=0, and rx_valid_o, tx_ack_o, busy_o, stop_o all 0. State=IDLE.
//  Input path: 2-FF synchronizer on SCL and SDA, then edge detect. Edges take effect 3 clk after the pad.
//  START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are valid in every state.
//  Repeated START in any state -> ADDR: bit counter cleared, SDA released, busy_o cleared.
//  STOP in any state -> IDLE, SDA released; stop_o pulses if busy_o was 1.
//  Bits are sampled on the SCL rising edge, MSB first. SDA changes only on the SCL falling edge.
//  FSM states: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
//   IDLE      -> ADDR on START.
//   ADDR      8 bits (7 address bits + R/W). On the 8th fall: match -> drive 0 and enter ADDR_ACK;
//             mismatch -> WAIT_STOP with SDA released.
//   ADDR_ACK  On the SCL fall that ends the ACK slot:
//             R/W=0 -> release SDA, go to RX_DATA.
//             R/W=1 -> load shift register with tx_data_i (0xFF if !tx_valid_i), pulse tx_ack_o
//             only if tx_valid_i, drive bit 7, go to TX_DATA.
//   RX_DATA   On the 8th rise: rx_data_o updates and rx_valid_o pulses, unless rx_full_i=1 (no pulse).
//             On the 8th fall: drive 0 (ACK) if the byte was accepted, else keep released (NACK).
//             Then RX_ACK.
//   RX_ACK    On the ending fall: release SDA. Accepted byte -> RX_DATA; NACKed byte -> WAIT_STOP.
//   TX_DATA   Shift out one bit per SCL fall. Release SDA on the 8th fall, then TX_ACK.
//   TX_ACK    Sample master ACK on the rise. ACK(0) -> reload on the ending fall exactly as in
//             ADDR_ACK, go to TX_DATA. NACK(1) -> WAIT_STOP with SDA released.
//   WAIT_STOP SDA released; waits for START or STOP.
//  Bit counter is 3 bits and wraps 7->0 at each byte; it is cleared on START.
//  Reset asserted mid-transfer releases SDA immediately (asynchronous). No ACK completes.
//  START or STOP and an SCL edge in the same sampled cycle: START/STOP wins and the SCL edge is ignored.
// CONFIGURATION
//  I2C_SLAVE_GLITCH_FILTER_EN defined:
//   - After the synchronizer, each line passes a 3-sample stable filter.
//   - The filtered value changes only after 3 equal consecutive samples, which rejects pulses of 2 clk or less.
//   - Pad-to-edge latency becomes 6 clk.
//  Not defined: synchronizer only; latency 3 clk; no pulse rejection.
// STRUCTURE
//  Shared include i2c_defs.vh holds:
//   - FSM state localparams (3-bit encoding)
//   - I2C_ACK=1'b0 and I2C_NACK=1'b1
//   - I2C_RW_READ=1'b1
//  Sub-module i2c_line_sync, instantiated once per line (SCL, SDA):
//   - synchronizer, optional filter, registered level, rise and fall pulses
//   - the filter macro is evaluated only inside this sub-module
// TESTING
//  1 Write 0x3C+W, then 0xA5 and 0x5A, then STOP -> ACK on address and both bytes;
//    rx_valid_o pulses twice with 0xA5 then 0x5A; stop_o pulses once.
//  2 Address 0x3D+W -> no ACK (SDA stays 1); busy_o stays 0; no rx_valid_o or stop_o pulse.
//  3 Read 0x3C+R with tx_data_i=0xC3, tx_valid_i=1; master ACKs one byte, then NACKs the second
//    (tx_data_i=0x81) -> SDA shows 0xC3 then 0x81; tx_ack_o pulses twice; slave enters WAIT_STOP.
//  4 Write with rx_full_i=1 during the 2nd byte -> 1st byte ACKed, 2nd byte NACKed, no 2nd rx_valid_o.
//  5 Repeated START after a write byte, then 0x3C+R with tx_valid_i=0 -> address ACKed;
//    SDA shows 0xFF; no tx_ack_o pulse.
//  6 reset_i pulsed while the slave drives ACK -> SDA=1 within the same cycle; after release the
//    next START is decoded normally. With the filter macro defined, 2-clk SDA glitches while SCL is
//    high cause no START or STOP.

Source files
------------

// File: rtl/i2c_slave_responder_pkg.sv
//============================================================================
// Package  : i2c_slave_responder_pkg
// Desc     : FSM state encoding, ACK/NACK levels and TX byte helper shared by
//            the I2C slave responder files.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package i2c_slave_responder_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_RX_DATA   = 3'd3;
    localparam logic [2:0] ST_RX_ACK    = 3'd4;
    localparam logic [2:0] ST_TX_DATA   = 3'd5;
    localparam logic [2:0] ST_TX_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    localparam logic [7:0] c_TX_FILL = 8'hFF;

    // An empty core still answers a read; the master then sees all ones.
    function automatic logic [7:0] tx_load_byte(input logic valid, input logic [7:0] data);
        return valid ? data : c_TX_FILL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
//============================================================================
// Module   : i2c_line_sync
// Desc     : 2-FF synchronizer for one I2C pad line with registered level and
//            rise/fall pulses. I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample
//            stable filter (pad-to-pulse latency 6 clk instead of 3).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_level;
    logic r_rise;
    logic r_fall;
    logic w_take;
    logic w_next;

    // Reset to the idle-bus level so leaving reset creates no false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 3'b111;
        end else begin
            r_hist <= {r_hist[1:0], r_sync};
        end
    end

    assign w_take = (r_hist == 3'b111) || (r_hist == 3'b000);
    assign w_next = r_hist[0];
`else
    assign w_take = 1'b1;
    assign w_next = r_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_take & w_next & ~r_level;
            r_fall <= w_take & ~w_next & r_level;
            if (w_take) begin
                r_level <= w_next;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_responder.sv
//============================================================================
// Module   : i2c_slave_responder
// Desc     : I2C target: START/STOP detect, 7-bit address match, byte receive
//            into the core and byte transmit from the core. Line filtering is
//            selected by I2C_SLAVE_GLITCH_FILTER_EN inside i2c_line_sync.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module i2c_slave_responder
    import i2c_slave_responder_pkg::*;
#(
    parameter int                  DATA_SIZE  = 8,
    parameter int                  ADDR_SIZE  = 7,
    parameter logic [ADDR_SIZE-1:0] SLAVE_ADDR = 7'h3C
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_i,
    input  logic                 i2c_scl_i,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_o,
    input  logic                 rx_full_i,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ack_o,
    output logic                 busy_o,
    output logic                 stop_o
);

    logic w_scl_level, w_scl_rise, w_scl_fall;
    logic w_sda_level, w_sda_rise, w_sda_fall;

    i2c_line_sync u_scl_sync (
        .clk     (i2c_core_clk_i),
        .rst     (reset_i),
        .i_line  (i2c_scl_i),
        .o_level (w_scl_level),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (i2c_core_clk_i),
        .rst     (reset_i),
        .i_line  (i2c_sda_i),
        .o_level (w_sda_level),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    logic [2:0]           r_state;
    logic [2:0]           r_bit_cnt;
    logic [DATA_SIZE-1:0] r_shift;
    logic                 r_got_rise;
    logic                 r_rw;
    logic                 r_accept;
    logic                 r_master_ack;
    logic                 r_sda;
    logic [DATA_SIZE-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_tx_ack;
    logic                 r_busy;
    logic                 r_stop;

    logic                 w_start;
    logic                 w_stop;
    logic [DATA_SIZE-1:0] w_shift_in;
    logic [DATA_SIZE-1:0] w_load;
    logic                 w_match;

    assign w_start    = w_sda_fall & w_scl_level;
    assign w_stop     = w_sda_rise & w_scl_level;
    assign w_shift_in = {r_shift[DATA_SIZE-2:0], w_sda_level};
    assign w_load     = tx_load_byte(tx_valid_i, tx_data_i);
    assign w_match    = (r_shift[DATA_SIZE-1 -: ADDR_SIZE] == SLAVE_ADDR);

    // A fall only ends a bit slot if a rise was seen in it; this skips the
    // SCL fall that immediately follows START.
    always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_got_rise   <= 1'b0;
            r_rw         <= 1'b0;
            r_accept     <= 1'b0;
            r_master_ack <= I2C_NACK;
            r_sda        <= 1'b1;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_tx_ack     <= 1'b0;
            r_busy       <= 1'b0;
            r_stop       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_stop     <= 1'b0;
            if (w_start) begin
                r_state    <= ST_ADDR;
                r_bit_cnt  <= 3'd0;
                r_sda      <= 1'b1;
                r_busy     <= 1'b0;
                r_got_rise <= 1'b0;
            end else if (w_stop) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 3'd0;
                r_sda      <= 1'b1;
                r_stop     <= r_busy;
                r_busy     <= 1'b0;
                r_got_rise <= 1'b0;
            end else if (w_scl_rise) begin
                r_got_rise <= 1'b1;
                case (r_state)
                    ST_ADDR: r_shift <= w_shift_in;
                    ST_RX_DATA: begin
                        r_shift <= w_shift_in;
                        if (r_bit_cnt == 3'd7) begin
                            r_accept <= ~rx_full_i;
                            if (!rx_full_i) begin
                                r_rx_data  <= w_shift_in;
                                r_rx_valid <= 1'b1;
                            end
                        end
                    end
                    ST_TX_ACK: r_master_ack <= w_sda_level;
                    default: ;
                endcase
            end else if (w_scl_fall && r_got_rise) begin
                r_got_rise <= 1'b0;
                case (r_state)
                    ST_ADDR: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_match) begin
                                r_sda   <= I2C_ACK;
                                r_rw    <= r_shift[0];
                                r_busy  <= 1'b1;
                                r_state <= ST_ADDR_ACK;
                            end else begin
                                r_sda   <= 1'b1;
                                r_state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (r_rw == I2C_RW_READ) begin
                            r_shift  <= w_load;
                            r_tx_ack <= tx_valid_i;
                            r_sda    <= w_load[DATA_SIZE-1];
                            r_state  <= ST_TX_DATA;
                        end else begin
                            r_sda   <= 1'b1;
                            r_state <= ST_RX_DATA;
                        end
                    end
                    ST_RX_DATA: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_sda   <= r_accept ? I2C_ACK : I2C_NACK;
                            r_state <= ST_RX_ACK;
                        end
                    end
                    ST_RX_ACK: begin
                        r_sda   <= 1'b1;
                        r_state <= r_accept ? ST_RX_DATA : ST_WAIT_STOP;
                    end
                    ST_TX_DATA: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_sda   <= 1'b1;
                            r_state <= ST_TX_ACK;
                        end else begin
                            r_sda   <= r_shift[DATA_SIZE-2];
                            r_shift <= {r_shift[DATA_SIZE-2:0], 1'b0};
                        end
                    end
                    ST_TX_ACK: begin
                        if (r_master_ack == I2C_ACK) begin
                            r_shift  <= w_load;
                            r_tx_ack <= tx_valid_i;
                            r_sda    <= w_load[DATA_SIZE-1];
                            r_state  <= ST_TX_DATA;
                        end else begin
                            r_sda   <= 1'b1;
                            r_state <= ST_WAIT_STOP;
                        end
                    end
                    default: r_sda <= 1'b1;
                endcase
            end
        end
    end

    assign i2c_sda_o  = r_sda;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign tx_ack_o   = r_tx_ack;
    assign busy_o     = r_busy;
    assign stop_o     = r_stop;

endmodule

`default_nettype wire
